// File: rtl/load_cache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped load cache.
package load_cache_pkg;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int INDEX_BITS = 4;
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int TAG_W      = ADDR_W - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;
endpackage

// File: rtl/load_cache_if.sv
// CPU request/response and memory load-port signals of the load cache.
interface load_cache_if;
    import load_cache_pkg::*;

    logic              reqValid;
    logic [ADDR_W-1:0] reqAddr;
    logic              reqReady;
    logic              respValid;
    logic [DATA_W-1:0] respData;
    logic              flush;
    logic              memLoadEnable;
    logic [ADDR_W-1:0] memLoadAddr;
    logic              memLoadReady;
    logic [DATA_W-1:0] memLoadData;
    logic [15:0]       hitCount;
    logic [15:0]       missCount;

    modport slave (
        input  reqValid, reqAddr, flush, memLoadReady, memLoadData,
        output reqReady, respValid, respData, memLoadEnable, memLoadAddr,
               hitCount, missCount
    );

    modport master (
        output reqValid, reqAddr, flush, memLoadReady, memLoadData,
        input  reqReady, respValid, respData, memLoadEnable, memLoadAddr,
               hitCount, missCount
    );
endinterface

// File: rtl/load_cache_array.sv
// Tag/valid/data storage: combinational read, one write port, flush clears all valid bits.
// Flush beats a same-cycle write so a line filled during a flush never becomes valid.
module lc_array
    import load_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_vld_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_dat_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_dat_i
);
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
        if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_vld_o = valid_q[rd_idx_i];
    assign rd_tag_o = tag_q[rd_idx_i];
    assign rd_dat_o = data_q[rd_idx_i];
endmodule

// File: rtl/load_cache.sv
// Direct-mapped read-only cache: hits respond 1 cycle after acceptance, misses 1 cycle after memLoadReady.
// One request in flight; reqReady is low outside IDLE and while flush is high.
module load_cache
    import load_cache_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    load_cache_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              resp_vld_q, resp_vld_d;
    logic [DATA_W-1:0] resp_dat_q, resp_dat_d;
    logic              drop_q, drop_d;
    logic [15:0]       hit_q, hit_d;
    logic [15:0]       miss_q, miss_d;

    logic              rd_vld;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_dat;
    logic              wr_en;
    logic              accept;
    logic              hit;

    lc_array u_array (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (bus.flush),
        .rd_idx_i (bus.reqAddr[INDEX_BITS-1:0]),
        .rd_vld_o (rd_vld),
        .rd_tag_o (rd_tag),
        .rd_dat_o (rd_dat),
        .wr_en_i  (wr_en),
        .wr_idx_i (addr_q[INDEX_BITS-1:0]),
        .wr_tag_i (addr_q[ADDR_W-1:INDEX_BITS]),
        .wr_dat_i (bus.memLoadData)
    );

    assign bus.reqReady      = (state_q == IDLE) && !bus.flush;
    assign accept            = bus.reqValid && bus.reqReady;
    assign hit               = rd_vld && (rd_tag == bus.reqAddr[ADDR_W-1:INDEX_BITS]);
    assign bus.respValid     = resp_vld_q;
    assign bus.respData      = resp_dat_q;
    assign bus.memLoadEnable = (state_q == ISSUE);
    assign bus.memLoadAddr   = (state_q == ISSUE) ? addr_q : '0;
    assign bus.hitCount      = hit_q;
    assign bus.missCount     = miss_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        resp_vld_d = 1'b0;
        resp_dat_d = '0;
        drop_d     = drop_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        resp_vld_d = 1'b1;
                        resp_dat_d = rd_dat;
                        hit_d      = hit_q + 16'd1;
                    end else begin
                        addr_d  = bus.reqAddr;
                        miss_d  = miss_q + 16'd1;
                        drop_d  = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.flush) drop_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.flush) drop_d = 1'b1;
                if (bus.memLoadReady) begin
                    // A flush in the fill cycle itself also suppresses the install.
                    wr_en      = !drop_q && !bus.flush;
                    resp_vld_d = 1'b1;
                    resp_dat_d = bus.memLoadData;
                    drop_d     = 1'b0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
            drop_q     <= 1'b0;
            hit_q      <= '0;
            miss_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
            drop_q     <= drop_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end
endmodule

// File: tb/tb_load_cache.sv
// Bench for load_cache: behavioural memory, transaction-level cache model checked every cycle, directed and random stimulus.
module tb_load_cache;
    import load_cache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    load_cache_if bus ();
    load_cache dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a == 16'h0005) return 16'h1234;
        if (a == 16'h0015) return 16'hBEEF;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memory: loadEnable restarts a countdown of mem_lat cycles, then loadReady pulses once.
    int          mem_lat = 4;
    int          mcnt    = 0;
    int          en_cnt  = 0;
    logic        en_s;
    logic [15:0] a_s, maddr;

    initial begin
        bus.memLoadReady = 1'b0;
        bus.memLoadData  = '0;
    end

    always @(negedge clk) begin
        en_s = bus.memLoadEnable;
        a_s  = bus.memLoadAddr;
        if (en_s === 1'b1) en_cnt++;
    end

    always @(posedge clk) begin
        #1;
        bus.memLoadReady = 1'b0;
        bus.memLoadData  = '0;
        if (en_s === 1'b1) begin
            mcnt  = mem_lat;
            maddr = a_s;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                bus.memLoadReady = 1'b1;
                bus.memLoadData  = memf(maddr);
            end
        end
    end

    // Reference model: lines hold full addresses; one outstanding miss at most.
    bit          m_on = 1'b0;
    bit          m_lv [LINES];
    logic [15:0] m_la [LINES];
    int          m_hits, m_miss;
    bit          m_resp_due, m_active, m_issue, m_wait, m_drop;
    logic [15:0] m_resp_val, m_addr;

    always @(negedge clk) begin
        bit          nresp, nissue;
        logic [15:0] nv;
        logic [3:0]  idx;
        if (m_on) begin
            check("reqReady",  32'(bus.reqReady),      32'(!m_active && !bus.flush));
            check("respValid", 32'(bus.respValid),     32'(m_resp_due));
            check("respData",  32'(bus.respData),      32'(m_resp_due ? m_resp_val : 16'h0));
            check("memEnable", 32'(bus.memLoadEnable), 32'(m_issue));
            check("memAddr",   32'(bus.memLoadAddr),   32'(m_issue ? m_addr : 16'h0));
            check("hitCount",  32'(bus.hitCount),      32'(16'(m_hits)));
            check("missCount", 32'(bus.missCount),     32'(16'(m_miss)));
        end
        if (reset === 1'b1) begin
            for (int i = 0; i < LINES; i++) begin
                m_lv[i] = 1'b0;
                m_la[i] = '0;
            end
            m_hits = 0; m_miss = 0;
            m_resp_due = 0; m_active = 0; m_issue = 0; m_wait = 0; m_drop = 0;
            m_resp_val = '0; m_addr = '0;
            m_on = 1'b1;
        end else if (m_on) begin
            nresp  = 1'b0;
            nissue = 1'b0;
            nv     = '0;
            if (!m_active) begin
                if (bus.reqValid && !bus.flush) begin
                    idx = bus.reqAddr[3:0];
                    if (m_lv[idx] && m_la[idx] == bus.reqAddr) begin
                        m_hits++;
                        nresp = 1'b1;
                        nv    = memf(bus.reqAddr);
                    end else begin
                        m_miss++;
                        m_active = 1'b1;
                        m_addr   = bus.reqAddr;
                        m_drop   = 1'b0;
                        nissue   = 1'b1;
                    end
                end
            end else if (m_issue) begin
                m_wait = 1'b1;
                if (bus.flush) m_drop = 1'b1;
            end else if (m_wait) begin
                if (bus.flush) m_drop = 1'b1;
                if (bus.memLoadReady) begin
                    m_wait = 1'b0;
                    nresp  = 1'b1;
                    nv     = memf(m_addr);
                    if (!m_drop) begin
                        m_lv[m_addr[3:0]] = 1'b1;
                        m_la[m_addr[3:0]] = m_addr;
                    end
                end
            end else begin
                m_active = 1'b0;
            end
            if (bus.flush) for (int i = 0; i < LINES; i++) m_lv[i] = 1'b0;
            m_resp_due = nresp;
            m_resp_val = nv;
            m_issue    = nissue;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] a, input bit hold);
        bit acc = 1'b0;
        bus.reqValid = 1'b1;
        bus.reqAddr  = a;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.reqReady;
            step();
        end
        if (!hold) bus.reqValid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(output logic [15:0] d, output int lat);
        bit got = 1'b0;
        lat = 0;
        d   = '0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (bus.respValid) begin
                got = 1'b1;
                d   = bus.respData;
            end
        end
        step();
        bus.reqValid = 1'b0;
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    logic [15:0] d;
    int          lat, e0, rcnt;

    initial begin
        reset = 1'b1;
        bus.reqValid = 1'b0;
        bus.reqAddr  = '0;
        bus.flush    = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_hits",  32'(bus.hitCount),  32'd0);
        check("rst_miss",  32'(bus.missCount), 32'd0);
        check("rst_ready", 32'(bus.reqReady),  32'd1);
        check("rst_resp",  32'(bus.respValid), 32'd0);
        step();

        // Cold miss with a 100-cycle memory.
        mem_lat = 100;
        e0 = en_cnt;
        accept(16'h0005, 1'b0);
        wait_resp(d, lat);
        check("cold_data", 32'(d), 32'h1234);
        check("cold_lat",  32'(lat), 32'd103);
        check("cold_en",   32'(en_cnt - e0), 32'd1);
        check("cold_miss", 32'(bus.missCount), 32'd1);

        // Hit on the installed line.
        e0 = en_cnt;
        accept(16'h0005, 1'b0);
        wait_resp(d, lat);
        check("hit_data", 32'(d), 32'h1234);
        check("hit_lat",  32'(lat), 32'd1);
        check("hit_en",   32'(en_cnt - e0), 32'd0);
        check("hit_cnt",  32'(bus.hitCount), 32'd1);

        // Conflicting addresses on index 5 evict each other.
        mem_lat = 5;
        accept(16'h0015, 1'b0);
        wait_resp(d, lat);
        check("conf_data1", 32'(d), 32'hBEEF);
        accept(16'h0005, 1'b0);
        wait_resp(d, lat);
        check("conf_data2", 32'(d), 32'h1234);
        check("conf_miss",  32'(bus.missCount), 32'd3);

        // reqValid held through a miss: only one transaction.
        e0 = en_cnt;
        accept(16'h0025, 1'b1);
        wait_resp(d, lat);
        check("busy_data", 32'(d), 32'(memf(16'h0025)));
        check("busy_en",   32'(en_cnt - e0), 32'd1);
        check("busy_miss", 32'(bus.missCount), 32'd4);

        // Flush while waiting: data delivered but not installed.
        mem_lat = 6;
        accept(16'h0033, 1'b0);
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        wait_resp(d, lat);
        check("flush_data", 32'(d), 32'(memf(16'h0033)));
        accept(16'h0033, 1'b0);
        wait_resp(d, lat);
        check("flush_refetch", 32'(bus.missCount), 32'd6);
        check("flush_hits",    32'(bus.hitCount),  32'd1);

        // Reset mid-miss; the stale loadReady must produce nothing.
        mem_lat = 20;
        accept(16'h0044, 1'b0);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.respValid) rcnt++;
            step();
        end
        check("rst_stale_resp", 32'(rcnt), 32'd0);
        mem_lat = 7;
        accept(16'h0044, 1'b0);
        wait_resp(d, lat);
        check("rst_new_data", 32'(d), 32'(memf(16'h0044)));
        check("rst_new_miss", 32'(bus.missCount), 32'd1);

        // Random traffic over a small address set to mix hits, conflicts, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            bus.reqValid = ($urandom_range(0, 2) != 0);
            bus.reqAddr  = 16'(($urandom_range(0, 2) << 4) | $urandom_range(0, 7));
            bus.flush    = ($urandom_range(0, 24) == 0);
            mem_lat      = $urandom_range(1, 6);
            step();
        end
        reset        = 1'b0;
        bus.reqValid = 1'b0;
        bus.flush    = 1'b0;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
